// File: rtl/riscv_pkg.sv
// Shared core constants and write-back FSM state encoding.
// Used by the register-file write-back arbiter and its grant logic.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [0:0] state_t;

  localparam state_t INIT = 1'b0;
  localparam state_t ARB  = 1'b1;

  localparam logic [REG_ADDR_W-1:0] LAST_REG =
    REG_ADDR_W'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_wb_rr_arb2.sv
// Two-input write-back grant logic, ALU vs load unit.
// REGFILE_WB_ARBITER_RR_EN: round-robin, else mem wins collisions.
module regfile_wb_rr_arb2 (
`ifdef REGFILE_WB_ARBITER_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic aluValid,
  input  logic memValid,
  output logic aluGrant,
  output logic memGrant
);

`ifdef REGFILE_WB_ARBITER_RR_EN
  logic ptrMem;

  assign memGrant = en & memValid
                  & (ptrMem | ~aluValid);
  assign aluGrant = en & aluValid
                  & (~ptrMem | ~memValid);

  // Pointer names the source that wins the next collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptrMem <= 1'b1;
    end else if (aluGrant) begin
      ptrMem <= 1'b1;
    end else if (memGrant) begin
      ptrMem <= 1'b0;
    end
  end
`else
  assign memGrant = en & memValid;
  assign aluGrant = en & aluValid & ~memValid;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port: clear sweep, then ALU/load arbitration.
// REGFILE_WB_ARBITER_RR_EN selects round-robin grant policy.
module regfile_wb_arbiter
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aluWbValid_in,
  input  logic [REG_ADDR_W-1:0] aluWbAddr_in,
  input  logic [XLEN-1:0]       aluWbData_in,
  output logic                  aluWbReady_out,
  input  logic                  memWbValid_in,
  input  logic [REG_ADDR_W-1:0] memWbAddr_in,
  input  logic [XLEN-1:0]       memWbData_in,
  output logic                  memWbReady_out,
  output logic                  regInWE_out,
  output logic [REG_ADDR_W-1:0] regInAddr_out,
  output logic [XLEN-1:0]       regIn_out,
  output logic                  initBusy_out,
  output logic [7:0]            collisionCnt_out
);

  state_t                state;
  logic [REG_ADDR_W-1:0] sweepCnt;
  logic                  arbEn;
  logic                  aluGrant;
  logic                  memGrant;
  logic                  collide;

  assign arbEn   = (state == ARB);
  assign collide = arbEn & aluWbValid_in & memWbValid_in;

  regfile_wb_rr_arb2 uArb (
`ifdef REGFILE_WB_ARBITER_RR_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .en       (arbEn),
    .aluValid (aluWbValid_in),
    .memValid (memWbValid_in),
    .aluGrant (aluGrant),
    .memGrant (memGrant)
  );

  assign aluWbReady_out = aluGrant;
  assign memWbReady_out = memGrant;
  assign initBusy_out   = (state == INIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= INIT;
      sweepCnt      <= '0;
      regInWE_out   <= 1'b0;
      regInAddr_out <= '0;
      regIn_out     <= '0;
    end else begin
      unique case (state)
        INIT: begin
          regInWE_out   <= 1'b1;
          regInAddr_out <= sweepCnt;
          regIn_out     <= '0;
          sweepCnt      <= sweepCnt + 1'b1;
          if (sweepCnt == LAST_REG) begin
            state <= ARB;
          end
        end
        default: begin
          // x0 is hardwired: accept the write, suppress the enable.
          unique case (1'b1)
            memGrant: begin
              regInWE_out   <= (memWbAddr_in != '0);
              regInAddr_out <= memWbAddr_in;
              regIn_out     <= memWbData_in;
            end
            aluGrant: begin
              regInWE_out   <= (aluWbAddr_in != '0);
              regInAddr_out <= aluWbAddr_in;
              regIn_out     <= aluWbData_in;
            end
            default: regInWE_out <= 1'b0;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collisionCnt_out <= '0;
    end else if (collide && collisionCnt_out != 8'hFF) begin
      collisionCnt_out <= collisionCnt_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Honours REGFILE_WB_ARBITER_RR_EN when compiled with it.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aluWbValid_in = 1'b0;
  logic [4:0]  aluWbAddr_in = '0;
  logic [31:0] aluWbData_in = '0;
  logic        aluWbReady_out;
  logic        memWbValid_in = 1'b0;
  logic [4:0]  memWbAddr_in = '0;
  logic [31:0] memWbData_in = '0;
  logic        memWbReady_out;
  logic        regInWE_out;
  logic [4:0]  regInAddr_out;
  logic [31:0] regIn_out;
  logic        initBusy_out;
  logic [7:0]  collisionCnt_out;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .aluWbValid_in    (aluWbValid_in),
    .aluWbAddr_in     (aluWbAddr_in),
    .aluWbData_in     (aluWbData_in),
    .aluWbReady_out   (aluWbReady_out),
    .memWbValid_in    (memWbValid_in),
    .memWbAddr_in     (memWbAddr_in),
    .memWbData_in     (memWbData_in),
    .memWbReady_out   (memWbReady_out),
    .regInWE_out      (regInWE_out),
    .regInAddr_out    (regInAddr_out),
    .regIn_out        (regIn_out),
    .initBusy_out     (initBusy_out),
    .collisionCnt_out (collisionCnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aV;
    logic [4:0]  aA;
    logic [31:0] aD;
    logic        mV;
    logic [4:0]  mA;
    logic [31:0] mD;
    logic        eAR;
    logic        eMR;
    logic        eWe;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    logic        chkAD;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic aV, input logic [4:0] aA,
                       input logic [31:0] aD, input logic mV,
                       input logic [4:0] mA, input logic [31:0] mD);
    aluWbValid_in = aV;
    aluWbAddr_in  = aA;
    aluWbData_in  = aD;
    memWbValid_in = mV;
    memWbAddr_in  = mA;
    memWbData_in  = mD;
  endtask

  task automatic doReset();
    rst = 1'b0;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst we", regInWE_out, 0);
    chk("rst addr", regInAddr_out, 0);
    chk("rst data", regIn_out, 0);
    chk("rst col", collisionCnt_out, 0);
    chk("rst busy", initBusy_out, 1);
    chk("rst aluRdy", aluWbReady_out, 0);
    chk("rst memRdy", memWbReady_out, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  // Clear sweep; optionally hold both valids high to prove no grants.
  task automatic sweep(input bit withValid);
    drive(withValid, 5'd6, 32'h66, withValid, 5'd7, 32'h77);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("init busy", initBusy_out, 1);
      chk("init aluRdy", aluWbReady_out, 0);
      chk("init memRdy", memWbReady_out, 0);
      @(posedge clk);
      #1;
      chk("init we", regInWE_out, 1);
      chk("init addr", regInAddr_out, i);
      chk("init data", regIn_out, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("post busy", initBusy_out, 0);
    chk("post col", collisionCnt_out, 0);
  endtask

  // Reference model state
  bit          prefMem;
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  int          mCol;

  initial begin
    bit   rr;
    bit   both, gA, gM;
    logic rAV, rMV;
    logic [4:0] rAA, rMA;
    logic [31:0] rAD, rMD;
`ifdef REGFILE_WB_ARBITER_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif

    tbl[0] = '{1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0,
               1, 0, 1, 5'd5, 32'h1234_5678, 1};
    tbl[1] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
               0, 0, 0, 5'd5, 32'h1234_5678, 1};
    tbl[2] = '{0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF,
               0, 1, 0, 5'd0, 32'h0, 0};
    tbl[3] = '{0, 5'd0, 32'h0, 1, 5'd7, 32'h77,
               0, 1, 1, 5'd7, 32'h77, 1};
    if (rr)
      tbl[4] = '{1, 5'd1, 32'hAAAA_AAAA, 1, 5'd2, 32'hBBBB_BBBB,
                 1, 0, 1, 5'd1, 32'hAAAA_AAAA, 1};
    else
      tbl[4] = '{1, 5'd1, 32'hAAAA_AAAA, 1, 5'd2, 32'hBBBB_BBBB,
                 0, 1, 1, 5'd2, 32'hBBBB_BBBB, 1};
    tbl[5] = '{1, 5'd9, 32'h99, 0, 5'd0, 32'h0,
               1, 0, 1, 5'd9, 32'h99, 1};
    tbl[6] = '{1, 5'd1, 32'hAAAA_AAAA, 1, 5'd2, 32'hBBBB_BBBB,
               0, 1, 1, 5'd2, 32'hBBBB_BBBB, 1};

    // Reset, sweep, then table vectors
    doReset();
    sweep(1'b0);
    foreach (tbl[i]) begin
      drive(tbl[i].aV, tbl[i].aA, tbl[i].aD,
            tbl[i].mV, tbl[i].mA, tbl[i].mD);
      #1;
      chk($sformatf("tbl%0d aluRdy", i), aluWbReady_out, tbl[i].eAR);
      chk($sformatf("tbl%0d memRdy", i), memWbReady_out, tbl[i].eMR);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d we", i), regInWE_out, tbl[i].eWe);
      if (tbl[i].chkAD) begin
        chk($sformatf("tbl%0d addr", i), regInAddr_out, tbl[i].eAddr);
        chk($sformatf("tbl%0d data", i), regIn_out, tbl[i].eData);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("tbl col", collisionCnt_out, 2);

    // Four collisions from a fresh reset, then saturation
    doReset();
    sweep(1'b1);
    for (int i = 0; i < 300; i++) begin
      bit expMem;
      drive(1, 5'd1, 32'hAAAA_AAAA, 1, 5'd2, 32'hBBBB_BBBB);
      expMem = rr ? (i % 2 == 0) : 1'b1;
      #1;
      if (i < 4) begin
        chk($sformatf("col%0d memRdy", i), memWbReady_out, expMem);
        chk($sformatf("col%0d aluRdy", i), aluWbReady_out, !expMem);
      end
      @(posedge clk);
      #1;
      if (i < 4) begin
        chk($sformatf("col%0d addr", i), regInAddr_out,
            expMem ? 5'd2 : 5'd1);
        chk($sformatf("col%0d data", i), regIn_out,
            expMem ? 32'hBBBB_BBBB : 32'hAAAA_AAAA);
      end
      if (i == 3)   chk("col cnt 4", collisionCnt_out, 4);
      if (i == 253) chk("col cnt 254", collisionCnt_out, 254);
      if (i == 254) chk("col cnt 255", collisionCnt_out, 255);
    end
    chk("col sat", collisionCnt_out, 255);
    drive(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-sweep at address 10
    doReset();
    repeat (11) @(posedge clk);
    #1;
    chk("mid addr10", regInAddr_out, 10);
    #2;
    rst = 1'b0;
    #1;
    chk("mid we", regInWE_out, 0);
    chk("mid addr", regInAddr_out, 0);
    chk("mid data", regIn_out, 0);
    chk("mid busy", initBusy_out, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sweep(1'b1);
    chk("mid col", collisionCnt_out, 0);

    // Randomised traffic against the model
    doReset();
    sweep(1'b0);
    prefMem = 1'b1;
    mWe = 1'b1;
    mAddr = 5'd31;
    mData = 32'h0;
    mCol = 0;
    rAV = 0; rMV = 0;
    rAA = 0; rMA = 0;
    rAD = 0; rMD = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!rAV && $urandom_range(0, 1) == 1) begin
        rAV = 1;
        rAA = 5'($urandom_range(0, 31));
        rAD = $urandom;
      end
      if (!rMV && $urandom_range(0, 2) != 0) begin
        rMV = 1;
        rMA = ($urandom_range(0, 7) == 0) ? 5'd0
                                          : 5'($urandom_range(1, 31));
        rMD = $urandom;
      end
      drive(rAV, rAA, rAD, rMV, rMA, rMD);
      both = rAV && rMV;
      gM = rMV && (!both || !rr || prefMem);
      gA = rAV && !gM;
      #1;
      chk("rnd aluRdy", aluWbReady_out, gA);
      chk("rnd memRdy", memWbReady_out, gM);
      @(posedge clk);
      #1;
      if (gM) begin
        mAddr = rMA; mData = rMD;
      end else if (gA) begin
        mAddr = rAA; mData = rAD;
      end
      mWe = (gA || gM) && (mAddr != 0);
      if (gA || gM) prefMem = gA;
      if (both && mCol < 255) mCol++;
      chk("rnd we", regInWE_out, mWe);
      chk("rnd addr", regInAddr_out, mAddr);
      chk("rnd data", regIn_out, mData);
      chk("rnd col", collisionCnt_out, mCol);
      if (gA) rAV = 0;
      if (gM) rMV = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
